// File: rtl/spi_adder_slave.sv
// spi_adder_slave: SPI slave that returns (previous word + ADDEND) full-duplex.
// Define SPI_ADDER_SAT_EN to saturate the sum at 2^WIDTH-1 instead of wrapping.
module spi_adder_slave #(
  parameter int WIDTH  = 8,
  parameter int ADDEND = 25,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic             clk,
  input  logic             negrst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             negss,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [15:0]      frame_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic             sclk_m_q, sclk_s_q, sclk_p_q, mosi_m_q, mosi_s_q, ss_m_q, ss_s_q;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d, result_q, result_d, rx_data_q, rx_data_d;
  logic [WIDTH-1:0] word, sum;
  logic             rx_valid_q, rx_valid_d, miso_q, miso_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             rise, fall, sample_edge, shift_edge;
  assign rise        = sclk_s_q & ~sclk_p_q;
  assign fall        = ~sclk_s_q & sclk_p_q;
  // Leading edge is the rise when CPOL=0; CPHA picks leading or trailing for sampling.
  assign sample_edge = (CPOL == CPHA) ? rise : fall;
  assign shift_edge  = (CPOL == CPHA) ? fall : rise;
  assign word        = {rx_shift_q, mosi_s_q};
`ifdef SPI_ADDER_SAT_EN
  logic [WIDTH:0] sum_w;
  assign sum_w = {1'b0, word} + (WIDTH+1)'(ADDEND);
  assign sum   = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
  assign sum = word + WIDTH'(ADDEND);
`endif
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    result_d    = result_q;
    rx_data_d   = rx_data_q;
    frame_cnt_d = frame_cnt_q;
    rx_valid_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!ss_s_q) begin
        state_d    = SHIFT;
        bit_cnt_d  = '0;
        tx_shift_d = result_q;
      end
    end else if (ss_s_q) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else if (sample_edge) begin
      rx_shift_d = word[WIDTH-2:0];
      if (bit_cnt_q == CW'(WIDTH-1)) begin
        bit_cnt_d   = '0;
        rx_data_d   = word;
        rx_valid_d  = 1'b1;
        result_d    = sum;
        tx_shift_d  = sum;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (shift_edge && bit_cnt_q != '0) begin
      tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
    end
    miso_d = (state_d == SHIFT) ? tx_shift_d[WIDTH-1] : 1'b0;
  end
  always_ff @(posedge clk or negedge negrst) begin
    if (!negrst) begin
      sclk_m_q    <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_p_q    <= 1'b0;
      mosi_m_q    <= 1'b0;
      mosi_s_q    <= 1'b0;
      ss_m_q      <= 1'b1;
      ss_s_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      result_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
      miso_q      <= 1'b0;
    end else begin
      sclk_m_q    <= sclk;
      sclk_s_q    <= sclk_m_q;
      sclk_p_q    <= sclk_s_q;
      mosi_m_q    <= mosi;
      mosi_s_q    <= mosi_m_q;
      ss_m_q      <= negss;
      ss_s_q      <= ss_m_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      result_q    <= result_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_cnt_q <= frame_cnt_d;
      miso_q      <= miso_d;
    end
  end
  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_spi_adder_slave.sv
// tb_spi_adder_slave: drives two slaves (default mode 0/8-bit, and CPOL=1 CPHA=1 16-bit)
// as an SPI master and checks them against a frame-level reference model.
module tb_spi_adder_slave;
  localparam int HP = 6;
  logic clk = 1'b0;
  logic negrst = 1'b0;
  logic sclk_a = 1'b0, mosi_a = 1'b0, ss_a = 1'b1;
  logic sclk_b = 1'b1, mosi_b = 1'b0, ss_b = 1'b1;
  logic miso_a, rx_valid_a, miso_b, rx_valid_b;
  logic [7:0] rx_data_a;
  logic [15:0] rx_data_b, frame_cnt_a, frame_cnt_b;
  int checks = 0, errors = 0;
  int vcnt_a = 0, vcnt_b = 0, vexp_a = 0, vexp_b = 0;
  logic [31:0] res_a, res_b, rxd_a, rxd_b;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  spi_adder_slave u_a (
    .clk(clk), .negrst(negrst), .sclk(sclk_a), .mosi(mosi_a), .negss(ss_a),
    .miso(miso_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_cnt(frame_cnt_a)
  );
  spi_adder_slave #(.WIDTH(16), .ADDEND(1), .CPOL(1), .CPHA(1)) u_b (
    .clk(clk), .negrst(negrst), .sclk(sclk_b), .mosi(mosi_b), .negss(ss_b),
    .miso(miso_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_cnt(frame_cnt_b)
  );

  always @(negedge clk) begin
    vcnt_a <= vcnt_a + (rx_valid_a === 1'b1 ? 1 : 0);
    vcnt_b <= vcnt_b + (rx_valid_b === 1'b1 ? 1 : 0);
  end

  function automatic logic [31:0] next_res(input logic [31:0] w, input int n, input int add);
    longint s, m;
    s = longint'(w) + longint'(add);
    m = (longint'(1) << n) - 1;
`ifdef SPI_ADDER_SAT_EN
    return 32'(s > m ? m : s);
`else
    return 32'(s & m);
`endif
  endfunction

  task automatic model_full(input bit sel, input logic [31:0] w);
    if (sel) begin
      rxd_b = w; res_b = next_res(w, 16, 1); cnt_b++; vexp_b++;
    end else begin
      rxd_a = w; res_a = next_res(w, 8, 25); cnt_a++; vexp_a++;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ss(input bit sel, input logic v);
    if (sel) ss_b = v; else ss_a = v;
  endtask

  task automatic set_sclk(input bit sel, input logic v);
    if (sel) sclk_b = v; else sclk_a = v;
  endtask

  task automatic set_mosi(input bit sel, input logic v);
    if (sel) mosi_b = v; else mosi_a = v;
  endtask

  // Shift nbits of w (MSB first) and collect miso LSB-justified; hold keeps negss low afterwards.
  task automatic spi_frame(input bit sel, input logic [31:0] w, input int nbits, input bit hold,
                           output logic [31:0] got);
    int n;
    n = sel ? 16 : 8;
    got = '0;
    if ((sel ? ss_b : ss_a) === 1'b1) begin
      set_ss(sel, 1'b0);
      wait_clk(HP);
    end
    for (int i = 0; i < nbits; i++) begin
      if (!sel) begin
        set_mosi(sel, w[n-1-i]);
        wait_clk(HP);
        got = {got[30:0], miso_a};
        set_sclk(sel, 1'b1);
        wait_clk(HP);
        set_sclk(sel, 1'b0);
      end else begin
        set_sclk(sel, 1'b0);
        set_mosi(sel, w[n-1-i]);
        wait_clk(HP);
        got = {got[30:0], miso_b};
        set_sclk(sel, 1'b1);
        wait_clk(HP);
      end
    end
    wait_clk(HP);
    if (!hold) begin
      set_ss(sel, 1'b1);
      wait_clk(2 * HP);
    end
  endtask

  task automatic do_reset();
    negrst = 1'b0;
    ss_a = 1'b1; sclk_a = 1'b0; mosi_a = 1'b0;
    ss_b = 1'b1; sclk_b = 1'b1; mosi_b = 1'b0;
    wait_clk(3);
    negrst = 1'b1;
    wait_clk(4);
    res_a = 0; rxd_a = 0; cnt_a = 0;
    res_b = 0; rxd_b = 0; cnt_b = 0;
  endtask

  task automatic test_reset();
    negrst = 1'b0;
    wait_clk(3);
    checks++;
    if ({miso_a, rx_data_a, rx_valid_a, frame_cnt_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got miso=%b rx_data=%h rx_valid=%b frame_cnt=%h, expected all 0",
               miso_a, rx_data_a, rx_valid_a, frame_cnt_a);
    end
    checks++;
    if ({miso_b, rx_data_b, rx_valid_b, frame_cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got miso=%b rx_data=%h rx_valid=%b frame_cnt=%h, expected all 0",
               miso_b, rx_data_b, rx_valid_b, frame_cnt_b);
    end
    do_reset();
  endtask

  task automatic test_zero_frames();
    logic [31:0] got;
    do_reset();
    spi_frame(0, 32'h00, 8, 0, got); model_full(0, 32'h00);
    spi_frame(0, 32'h00, 8, 0, got); model_full(0, 32'h00);
    checks++;
    if (got[7:0] !== 8'd25) begin
      errors++; $display("FAIL zero_miso: got %h expected %h", got[7:0], 8'd25);
    end
    checks++;
    if (frame_cnt_a !== 16'd2) begin
      errors++; $display("FAIL zero_frame_cnt: got %0d expected 2", frame_cnt_a);
    end
    checks++;
    if (vcnt_a !== vexp_a) begin
      errors++; $display("FAIL zero_rx_valid: got %0d pulses expected %0d", vcnt_a, vexp_a);
    end
  endtask

  task automatic test_add();
    logic [31:0] got;
    do_reset();
    spi_frame(0, 32'h0A, 8, 0, got); model_full(0, 32'h0A);
    checks++;
    if (rx_data_a !== 8'h0A) begin
      errors++; $display("FAIL add_rx_data: got %h expected 0a", rx_data_a);
    end
    spi_frame(0, 32'h00, 8, 0, got); model_full(0, 32'h00);
    checks++;
    if (got[7:0] !== 8'd35) begin
      errors++; $display("FAIL add_miso: got %h expected %h", got[7:0], 8'd35);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got, w;
    logic [7:0] exp;
    do_reset();
    spi_frame(0, 32'hF0, 8, 0, got); model_full(0, 32'hF0);
    w = 32'($urandom_range(0, 255));
`ifdef SPI_ADDER_SAT_EN
    exp = 8'hFF;
`else
    exp = 8'h09;
`endif
    spi_frame(0, w, 8, 0, got); model_full(0, w);
    checks++;
    if (got[7:0] !== exp) begin
      errors++; $display("FAIL overflow_miso: got %h expected %h", got[7:0], exp);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    int v0;
    do_reset();
    v0 = vcnt_a;
    spi_frame(0, 32'h05, 3, 0, got);
    checks++;
    if (vcnt_a !== v0) begin
      errors++; $display("FAIL abort_rx_valid: got %0d pulses expected %0d", vcnt_a - v0, 0);
    end
    spi_frame(0, 32'h01, 8, 0, got); model_full(0, 32'h01);
    checks++;
    if (got[7:0] !== 8'h00) begin
      errors++; $display("FAIL abort_miso: got %h expected 00", got[7:0]);
    end
    checks++;
    if (frame_cnt_a !== 16'd1) begin
      errors++; $display("FAIL abort_frame_cnt: got %0d expected 1", frame_cnt_a);
    end
    checks++;
    if (rx_data_a !== 8'h01) begin
      errors++; $display("FAIL abort_rx_data: got %h expected 01", rx_data_a);
    end
  endtask

  task automatic test_mode3_wide();
    logic [31:0] got;
    do_reset();
    spi_frame(1, 32'h1234, 16, 0, got); model_full(1, 32'h1234);
    checks++;
    if (rx_data_b !== 16'h1234) begin
      errors++; $display("FAIL mode3_rx_data: got %h expected 1234", rx_data_b);
    end
    spi_frame(1, 32'h0000, 16, 0, got); model_full(1, 32'h0000);
    checks++;
    if (got[15:0] !== 16'h1235) begin
      errors++; $display("FAIL mode3_miso: got %h expected 1235", got[15:0]);
    end
    checks++;
    if (frame_cnt_b !== 16'd2 || vcnt_b !== vexp_b) begin
      errors++;
      $display("FAIL mode3_count: got frame_cnt=%0d pulses=%0d expected 2 and %0d",
               frame_cnt_b, vcnt_b, vexp_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    logic [31:0] ws [4] = '{32'h11, 32'h22, 32'hE9, 32'h33};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp = res_a;
      spi_frame(0, ws[i], 8, i != 3, got); model_full(0, ws[i]);
      checks++;
      if (got[7:0] !== exp[7:0]) begin
        errors++; $display("FAIL b2b_miso[%0d]: got %h expected %h", i, got[7:0], exp[7:0]);
      end
    end
    checks++;
    if (frame_cnt_a !== cnt_a || rx_data_a !== rxd_a[7:0] || vcnt_a !== vexp_a) begin
      errors++;
      $display("FAIL b2b_state: got cnt=%0d rx=%h pulses=%0d expected %0d %h %0d",
               frame_cnt_a, rx_data_a, vcnt_a, cnt_a, rxd_a[7:0], vexp_a);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp, w, mask;
    int nb;
    bit partial, hold;
    for (int i = 0; i < 24; i++) begin
      w = 32'($urandom_range(0, 255));
      partial = ($urandom_range(0, 4) == 0);
      hold = partial ? 1'b0 : 1'($urandom_range(0, 1));
      nb = partial ? $urandom_range(1, 7) : 8;
      mask = (32'd1 << nb) - 1;
      exp = (res_a >> (8 - nb)) & mask;
      spi_frame(0, w, nb, hold, got);
      if (!partial) model_full(0, w);
      checks++;
      if ((got & mask) !== exp) begin
        errors++; $display("FAIL rand_miso[%0d]: got %h expected %h (%0d bits)", i, got & mask, exp, nb);
      end
      checks++;
      if (frame_cnt_a !== cnt_a || rx_data_a !== rxd_a[7:0] || vcnt_a !== vexp_a) begin
        errors++;
        $display("FAIL rand_state[%0d]: got cnt=%0d rx=%h pulses=%0d expected %0d %h %0d",
                 i, frame_cnt_a, rx_data_a, vcnt_a, cnt_a, rxd_a[7:0], vexp_a);
      end
    end
    set_ss(0, 1'b1);
    wait_clk(2 * HP);
    checks++;
    if (miso_a !== 1'b0) begin
      errors++; $display("FAIL idle_miso: got %b expected 0", miso_a);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    do_reset();
    spi_frame(0, 32'h07, 8, 0, got); model_full(0, 32'h07);
    spi_frame(0, 32'hA5, 4, 1, got);
    #2 negrst = 1'b0;
    #1;
    checks++;
    if ({miso_a, rx_data_a, rx_valid_a, frame_cnt_a} !== '0) begin
      errors++;
      $display("FAIL async_reset: got miso=%b rx_data=%h rx_valid=%b frame_cnt=%h, expected all 0",
               miso_a, rx_data_a, rx_valid_a, frame_cnt_a);
    end
    do_reset();
    spi_frame(0, 32'h00, 8, 0, got); model_full(0, 32'h00);
    checks++;
    if (got[7:0] !== 8'h00) begin
      errors++; $display("FAIL post_reset_miso: got %h expected 00", got[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frames();
    test_add();
    test_overflow();
    test_abort();
    test_mode3_wide();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
